piso_serializer: RTL and testbench
==================================

// Module: piso_serializer
// PURPOSE
//  Parallel-in/serial-out transmitter for the register library. Accepts a WIDTH-bit word via a
//  valid/ready load handshake and shifts it out one bit per clock on sout, qualified by sout_valid.
//  It is the transmit end of the serial-in/parallel-out register path. It sits between a
//  parallel producer and a single-wire serial link.
// PARAMETERS
//  WIDTH      8   bits per word; legal range >= 2
//  MSB_FIRST  1   1: bit WIDTH-1 is transmitted first; 0: bit 0 is transmitted first
// PORTS
//  clk         in   1      single clock; all state updates on rising edge
//  reset       in   1      asynchronous, active-high reset
//  clear       in   1      synchronous clear; aborts any transfer
//  din         in   WIDTH  parallel word to transmit
//  load_valid  in   1      producer offers din
//  load_ready  out  1      serializer can accept din this cycle
//  sout        out  1      serial data bit
//  sout_valid  out  1      sout carries a valid bit this cycle
//  last        out  1      high while the final bit of a word is on sout
// BEHAVIOUR
//  - States: IDLE, SHIFT. State, shift register sreg[WIDTH-1:0] and bit counter cnt are registered.
//  - Reset (async, immediate, also mid-word): state=IDLE, sreg=0, cnt=0.
//    Resulting outputs: sout=0, sout_valid=0, last=0, load_ready=1.
//  - Outputs are combinational from registered state:
//    sout_valid = (state==SHIFT).
//    sout = sout_valid ? (MSB_FIRST ? sreg[WIDTH-1] : sreg[0]) : 0.
//    last = sout_valid & (cnt==0).
//    load_ready = (state==IDLE) | last.
//  - Load accepted at a rising edge when load_valid & load_ready & ~clear.
//    On acceptance: sreg<=din, cnt<=WIDTH-1, state<=SHIFT.
//  - Latency: first bit appears on sout in the cycle after the accepting edge.
//    A word occupies exactly WIDTH consecutive sout_valid cycles.
//  - SHIFT with cnt!=0: shift sreg one place toward the output end
//    (left if MSB_FIRST, else right), fill with 0; cnt<=cnt-1.
//  - SHIFT with cnt==0 (last bit):
//    - If a load is accepted on this edge, reload and stay in SHIFT. This gives back-to-back
//      words with no gap.
//    - Otherwise go to IDLE, with sreg<=0.
//  - load_valid while load_ready=0 is ignored. din is not sampled and no error is raised.
//    The producer holds din/load_valid until accepted.
//  - clear has priority over load and over shifting:
//    state<=IDLE, sreg<=0, cnt<=0. A coincident load is NOT accepted.
//  - reset has priority over clear.
//  - Counter width: $clog2(WIDTH). Decrement never underflows, because cnt==0 always exits
//    or reloads.
//  - No X on any output after reset deassertion, independent of din.
// STRUCTURE
//  - Shared package/header serial_pkg:
//    - state encoding localparams ST_IDLE=1'b0, ST_SHIFT=1'b1
//    - the $clog2-based CNT_W computation
//    - these are shared with the matching deserializer
//  - One natural sub-module: bit_down_counter (load, decrement, zero flag, async active-high
//    reset, sync clear).
//  - FSM and shift register stay in this module.
// TESTING
//  1. Reset: assert reset mid-word (cycle 3 of 8).
//     -> same cycle: sout=0, sout_valid=0, last=0, load_ready=1; no residual bits afterwards.
//  2. Single word, WIDTH=8, MSB_FIRST=1, din=8'hA5.
//     -> sout sequence 1,0,1,0,0,1,0,1 over 8 valid cycles; last only on the 8th; then IDLE.
//  3. MSB_FIRST=0, din=8'h01.
//     -> sout = 1 then seven 0s; a following word is not accepted before last.
//  4. Back-to-back: load 8'hF0, then 8'h0F presented with load_valid held.
//     -> accepted on last edge; 16 contiguous valid bits 11110000_00001111.
//  5. clear asserted in cycle 4 together with load_valid=1.
//     -> next cycle IDLE, sout_valid=0, load not taken; the next load restarts from bit 0.
//  6. load_valid with din changing while busy.
//     -> transmitted word unchanged; the new din is captured only at the handshake edge.

Source files
------------

// File: rtl/serial_pkg.sv
// Package: serial_pkg
// Purpose : Definitions shared by the serializer and the matching deserializer.
//           It holds the FSM state encoding and the bit-counter width rule.
// Contents: state_t   - IDLE/SHIFT encoding (ST_IDLE=1'b0, ST_SHIFT=1'b1)
//           cnt_width - counter width for a given word width ($clog2, minimum 1)
package serial_pkg;

   typedef enum logic {
      ST_IDLE  = 1'b0,
      ST_SHIFT = 1'b1
   } state_t;

   // The counter holds values from WIDTH-1 down to 0, so $clog2(WIDTH) bits are enough.
   function automatic int cnt_width(input int width);
      return ($clog2(width) < 1) ? 1 : $clog2(width);
   endfunction

endpackage

// File: rtl/piso_serializer_if.sv
// Interface: piso_serializer_if
// Purpose  : Groups the load handshake and the serial output of piso_serializer.
// Signals  : din        - parallel word offered by the producer
//            load_valid - producer offers din
//            load_ready - serializer accepts din this cycle
//            sout       - serial data bit
//            sout_valid - sout carries a valid bit
//            last       - final bit of a word is on sout
// Modports : master - producer / link side (drives din, load_valid)
//            slave  - serializer side
interface piso_serializer_if #(
   parameter int WIDTH = 8
);
   logic [WIDTH-1:0] din;
   logic             load_valid;
   logic             load_ready;
   logic             sout;
   logic             sout_valid;
   logic             last;

   modport master (
      output din,
      output load_valid,
      input  load_ready,
      input  sout,
      input  sout_valid,
      input  last
   );

   modport slave (
      input  din,
      input  load_valid,
      output load_ready,
      output sout,
      output sout_valid,
      output last
   );
endinterface

// File: rtl/piso_serializer_bit_down_counter.sv
// Module : bit_down_counter
// Purpose: Bit counter for the serializer. It loads a start value and counts down to zero.
//          It flags zero and holds at zero, so it never wraps.
// Ports  : clk        - clock, rising edge
//          reset      - asynchronous active-high reset (count -> 0)
//          clear      - synchronous clear (count -> 0); beats load and decrement
//          load       - load load_value; beats decrement
//          load_value - start value
//          dec        - decrement request
//          cnt        - current count
//          zero       - count equals zero
module bit_down_counter #(
   parameter int CNT_W = 3
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             clear,
   input  logic             load,
   input  logic [CNT_W-1:0] load_value,
   input  logic             dec,
   output logic [CNT_W-1:0] cnt,
   output logic             zero
);
   logic [CNT_W-1:0] cnt_reg;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         cnt_reg <= '0;
      end else if (clear) begin
         cnt_reg <= '0;
      end else if (load) begin
         cnt_reg <= load_value;
      end else if (dec && (cnt_reg != '0)) begin
         cnt_reg <= cnt_reg - 1'b1;
      end
   end

   assign cnt  = cnt_reg;
   assign zero = (cnt_reg == '0);
endmodule

// File: rtl/piso_serializer.sv
// Module : piso_serializer
// Purpose: Parallel-in/serial-out transmitter. It accepts a WIDTH-bit word on a valid/ready
//          handshake and sends it on sout at one bit per clock, qualified by sout_valid.
//          'last' marks the final bit. A new word can be accepted on the last-bit edge,
//          so back-to-back words have no gap.
// Params : WIDTH     - bits per word (>= 2)
//          MSB_FIRST - 1: bit WIDTH-1 goes first, 0: bit 0 goes first
// Ports  : clk   - clock, rising edge
//          reset - asynchronous active-high reset
//          clear - synchronous abort; beats load and shifting
//          bus   - piso_serializer_if slave
//                  (din, load_valid, load_ready, sout, sout_valid, last)
module piso_serializer
   import serial_pkg::*;
#(
   parameter int WIDTH     = 8,
   parameter bit MSB_FIRST = 1'b1
) (
   input  logic                clk,
   input  logic                reset,
   input  logic                clear,
   piso_serializer_if.slave    bus
);
   localparam int CNT_W = cnt_width(WIDTH);

   state_t           state_reg;
   logic [WIDTH-1:0] sreg_reg;
   logic [CNT_W-1:0] cnt;
   logic             cnt_zero;

   logic shifting;
   logic last_bit;
   logic ready;
   logic accept;

   assign shifting = (state_reg == ST_SHIFT);
   assign last_bit = shifting & cnt_zero;
   // The last-bit cycle is also a load slot. This is what closes the gap between words.
   assign ready    = ~shifting | last_bit;
   assign accept   = bus.load_valid & ready & ~clear;

   bit_down_counter #(
      .CNT_W (CNT_W)
   ) u_cnt (
      .clk        (clk),
      .reset      (reset),
      .clear      (clear),
      .load       (accept),
      .load_value (CNT_W'(WIDTH - 1)),
      .dec        (shifting & ~cnt_zero),
      .cnt        (cnt),
      .zero       (cnt_zero)
   );

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_reg <= ST_IDLE;
         sreg_reg  <= '0;
      end else if (clear) begin
         state_reg <= ST_IDLE;
         sreg_reg  <= '0;
      end else if (accept) begin
         state_reg <= ST_SHIFT;
         sreg_reg  <= bus.din;
      end else if (shifting) begin
         if (!cnt_zero) begin
            // Move the next bit toward the output end and back-fill with zero.
            sreg_reg <= MSB_FIRST ? {sreg_reg[WIDTH-2:0], 1'b0}
                                  : {1'b0, sreg_reg[WIDTH-1:1]};
         end else begin
            state_reg <= ST_IDLE;
            sreg_reg  <= '0;
         end
      end
   end

   assign bus.sout_valid = shifting;
   assign bus.sout       = shifting & (MSB_FIRST ? sreg_reg[WIDTH-1] : sreg_reg[0]);
   assign bus.last       = last_bit;
   assign bus.load_ready = ready;

   // cnt is only needed through its zero flag here.
   logic unused_cnt;
   assign unused_cnt = ^cnt;
endmodule

// File: tb/tb_piso_serializer.sv
module tb_piso_serializer;
   localparam int W = 8;

   logic clk   = 1'b0;
   logic reset = 1'b1;
   logic clear = 1'b0;

   always #5 clk = ~clk;

   piso_serializer_if #(.WIDTH(W)) bus_m ();
   piso_serializer_if #(.WIDTH(W)) bus_l ();

   piso_serializer #(.WIDTH(W), .MSB_FIRST(1'b1)) dut_m (
      .clk   (clk),
      .reset (reset),
      .clear (clear),
      .bus   (bus_m.slave)
   );

   piso_serializer #(.WIDTH(W), .MSB_FIRST(1'b0)) dut_l (
      .clk   (clk),
      .reset (reset),
      .clear (clear),
      .bus   (bus_l.slave)
   );

   // Reference model: one queue per DUT holding the bits still to appear on sout, in order.
   bit q_m[$];
   bit q_l[$];

   int n_pass  = 0;
   int n_total = 0;

   logic [15:0] coll_m;   // MSB-first stream, newest bit enters at bit 0
   logic [15:0] coll_l;   // LSB-first stream, newest bit enters at bit 15
   int          nvalid;

   task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
      n_total++;
      assert (obs === exp) n_pass++;
      else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
   endtask

   task automatic check_dut(input string tag, input int qsize, input bit head,
                            input logic so, input logic sv, input logic la, input logic lr);
      chk({tag, ".sout_valid"}, 16'(sv), 16'(qsize > 0));
      chk({tag, ".sout"},       16'(so), 16'((qsize > 0) ? head : 1'b0));
      chk({tag, ".last"},       16'(la), 16'(qsize == 1));
      chk({tag, ".load_ready"}, 16'(lr), 16'(qsize <= 1));
   endtask

   task automatic set_in(input logic [W-1:0] d, input logic v);
      bus_m.din        = d;
      bus_l.din        = d;
      bus_m.load_valid = v;
      bus_l.load_valid = v;
   endtask

   // One clock: check outputs against the model, collect bits, advance the model at the edge.
   task automatic cycle();
      bit acc;
      check_dut("msb", q_m.size(), (q_m.size() > 0) ? q_m[0] : 1'b0,
                bus_m.sout, bus_m.sout_valid, bus_m.last, bus_m.load_ready);
      check_dut("lsb", q_l.size(), (q_l.size() > 0) ? q_l[0] : 1'b0,
                bus_l.sout, bus_l.sout_valid, bus_l.last, bus_l.load_ready);
      if (bus_m.sout_valid === 1'b1) begin
         coll_m = {coll_m[14:0], bus_m.sout};
         nvalid++;
      end
      if (bus_l.sout_valid === 1'b1) coll_l = {bus_l.sout, coll_l[15:1]};
      @(posedge clk);
      if (clear) begin
         q_m.delete();
         q_l.delete();
      end else begin
         acc = bus_m.load_valid && (q_m.size() <= 1);
         if (q_m.size() > 0) void'(q_m.pop_front());
         if (q_l.size() > 0) void'(q_l.pop_front());
         if (acc) begin
            for (int i = W - 1; i >= 0; i--) q_m.push_back(bus_m.din[i]);
            for (int i = 0; i < W; i++)      q_l.push_back(bus_l.din[i]);
         end
      end
      @(negedge clk);
   endtask

   task automatic run(input int n);
      for (int i = 0; i < n; i++) cycle();
   endtask

   initial begin
      set_in(8'h00, 1'b0);
      coll_m = '0;
      coll_l = '0;
      nvalid = 0;

      // Reset values while reset is held.
      @(posedge clk);
      #1;
      chk("rst.sout",       16'(bus_m.sout),       16'd0);
      chk("rst.sout_valid", 16'(bus_m.sout_valid), 16'd0);
      chk("rst.last",       16'(bus_m.last),       16'd0);
      chk("rst.load_ready", 16'(bus_m.load_ready), 16'd1);
      @(negedge clk);
      reset = 1'b0;
      run(2);

      // Single word 8'hA5 on both bit orders.
      set_in(8'hA5, 1'b1);
      run(1);
      set_in(8'h00, 1'b0);
      nvalid = 0;
      run(9);
      chk("a5.msb_word", {8'h00, coll_m[7:0]}, 16'h00A5);
      chk("a5.lsb_word", {8'h00, coll_l[15:8]}, 16'h00A5);
      chk("a5.nvalid",   16'(nvalid), 16'd8);

      // 8'h01, with a second word held pending; it may only go in on the last edge.
      set_in(8'h01, 1'b1);
      run(1);
      set_in(8'h3C, 1'b1);
      run(8);
      chk("w01.msb_word", {8'h00, coll_m[7:0]}, 16'h0001);
      chk("w01.lsb_word", {8'h00, coll_l[15:8]}, 16'h0001);
      set_in(8'h00, 1'b0);
      run(8);
      chk("w3c.msb_word", {8'h00, coll_m[7:0]}, 16'h003C);
      chk("w3c.lsb_word", {8'h00, coll_l[15:8]}, 16'h003C);
      run(2);

      // Back-to-back F0 then 0F with no gap.
      set_in(8'hF0, 1'b1);
      run(1);
      set_in(8'h0F, 1'b1);
      nvalid = 0;
      run(8);
      set_in(8'h00, 1'b0);
      run(8);
      chk("b2b.stream", coll_m, 16'hF00F);
      chk("b2b.nvalid", 16'(nvalid), 16'd16);
      run(2);

      // clear in the 4th bit cycle with a coincident load; the load must be dropped.
      set_in(8'hA5, 1'b1);
      run(1);
      set_in(8'h00, 1'b0);
      run(3);
      clear = 1'b1;
      set_in(8'hC3, 1'b1);
      run(1);
      clear = 1'b0;
      set_in(8'h00, 1'b0);
      chk("clr.idle", 16'(bus_m.sout_valid), 16'd0);
      run(1);
      set_in(8'h81, 1'b1);
      run(1);
      set_in(8'h00, 1'b0);
      nvalid = 0;
      run(9);
      chk("clr.next_word", {8'h00, coll_m[7:0]}, 16'h0081);
      chk("clr.nvalid",    16'(nvalid), 16'd8);

      // din wanders while busy; only the value at each handshake edge may be sent.
      for (int i = 0; i < 40; i++) begin
         set_in(8'($urandom), 1'b1);
         run(1);
      end
      set_in(8'h00, 1'b0);
      run(10);

      // Asynchronous reset in the middle of a word.
      set_in(8'hFF, 1'b1);
      run(1);
      set_in(8'h00, 1'b0);
      run(2);
      #2 reset = 1'b1;
      #1;
      chk("mid_rst.sout",       16'(bus_m.sout),       16'd0);
      chk("mid_rst.sout_valid", 16'(bus_m.sout_valid), 16'd0);
      chk("mid_rst.last",       16'(bus_m.last),       16'd0);
      chk("mid_rst.load_ready", 16'(bus_m.load_ready), 16'd1);
      chk("mid_rst.lsb_valid",  16'(bus_l.sout_valid), 16'd0);
      q_m.delete();
      q_l.delete();
      @(posedge clk);
      @(negedge clk);
      reset = 1'b0;
      run(10);

      // Random mix of loads, clears and data.
      for (int i = 0; i < 300; i++) begin
         clear = ($urandom_range(0, 15) == 0);
         set_in(8'($urandom), 1'($urandom_range(0, 1)));
         run(1);
      end
      clear = 1'b0;
      set_in(8'h00, 1'b0);
      run(10);

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end
endmodule
